// File: rtl/mono_frame_scheduler.sv
// Ping-pong framer: packs mono samples into FRAME_LEN-sample banks and streams each full bank
// out as one AXI4-Stream packet, dropping and counting samples when both banks are occupied.
module mono_frame_scheduler #(
   parameter int DATA_WIDTH     = 32,
   parameter int SAMPLE_WIDTH   = 24,
   parameter int FRAME_LEN_LOG2 = 8,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                    S_AXIS_ACLK,
   input  logic                    S_AXIS_ARESET,
   input  logic                    mono_sample_valid,
   input  logic [SAMPLE_WIDTH-1:0] mono_sample,
   output logic                    M_AXIS_TVALID,
   input  logic                    M_AXIS_TREADY,
   output logic [DATA_WIDTH-1:0]   M_AXIS_TDATA,
   output logic                    M_AXIS_TLAST,
   output logic                    frame_overrun,
   output logic [CNT_WIDTH-1:0]    overrun_count
);

   localparam int IDX_W = FRAME_LEN_LOG2;
   localparam int DEPTH = 2 << FRAME_LEN_LOG2;
   localparam logic [IDX_W-1:0] IDX_LAST = '1;

   typedef enum logic [1:0] {
      RD_IDLE   = 2'd0,
      RD_FETCH  = 2'd1,
      RD_STREAM = 2'd2
   } rd_state_t;

   logic [SAMPLE_WIDTH-1:0] mem_q [0:DEPTH-1];
   logic [SAMPLE_WIDTH-1:0] rd_data_q;

   logic                  wr_bank_q;
   logic [IDX_W-1:0]      wr_idx_q;
   logic [1:0]            full_q;
   logic [1:0]            full_d;
   logic                  rd_bank_q;
   logic [IDX_W-1:0]      rd_idx_q;
   rd_state_t             rd_state_q;
   logic                  tvalid_q;
   logic                  tlast_q;
   logic                  overrun_q;
   logic [CNT_WIDTH-1:0]  count_q;

   logic                  wr_en;
   logic                  wr_drop;
   logic                  wr_wrap;
   logic                  beat;
   logic                  frame_done;
   logic [IDX_W-1:0]      rd_addr_idx;

   always_comb begin
      wr_en       = mono_sample_valid && !full_q[wr_bank_q];
      wr_drop     = mono_sample_valid &&  full_q[wr_bank_q];
      wr_wrap     = wr_en && (wr_idx_q == IDX_LAST);
      beat        = tvalid_q && M_AXIS_TREADY;
      frame_done  = beat && tlast_q;
      // Advance the read address on an accepted beat so the next sample is ready one cycle later;
      // otherwise re-read the same address, which keeps TDATA stable under backpressure.
      rd_addr_idx = (beat && !tlast_q) ? rd_idx_q + IDX_W'(1) : rd_idx_q;
      full_d      = full_q;
      if (wr_wrap)    full_d[wr_bank_q] = 1'b1;
      if (frame_done) full_d[rd_bank_q] = 1'b0;
   end

   always_ff @(posedge S_AXIS_ACLK) begin
      if (wr_en) mem_q[{wr_bank_q, wr_idx_q}] <= mono_sample;
      rd_data_q <= mem_q[{rd_bank_q, rd_addr_idx}];
   end

   always_ff @(posedge S_AXIS_ACLK) begin
      if (S_AXIS_ARESET) begin
         wr_bank_q  <= 1'b0;
         wr_idx_q   <= '0;
         full_q     <= '0;
         rd_bank_q  <= 1'b0;
         rd_idx_q   <= '0;
         rd_state_q <= RD_IDLE;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
         overrun_q  <= 1'b0;
         count_q    <= '0;
      end else begin
         full_q    <= full_d;
         overrun_q <= wr_drop;
         if (wr_drop && (count_q != '1)) count_q <= count_q + CNT_WIDTH'(1);
         if (wr_en) begin
            wr_idx_q <= wr_idx_q + IDX_W'(1);
            if (wr_wrap) wr_bank_q <= ~wr_bank_q;
         end

         case (rd_state_q)
            RD_IDLE: begin
               if (full_q[rd_bank_q]) rd_state_q <= RD_FETCH;
            end
            RD_FETCH: begin
               rd_state_q <= RD_STREAM;
               tvalid_q   <= 1'b1;
               tlast_q    <= (rd_idx_q == IDX_LAST);
            end
            RD_STREAM: begin
               if (frame_done) begin
                  rd_state_q <= RD_IDLE;
                  tvalid_q   <= 1'b0;
                  tlast_q    <= 1'b0;
                  rd_bank_q  <= ~rd_bank_q;
                  rd_idx_q   <= '0;
               end else if (beat) begin
                  rd_idx_q <= rd_addr_idx;
                  tlast_q  <= (rd_addr_idx == IDX_LAST);
               end
            end
            default: begin
               rd_state_q <= RD_IDLE;
               tvalid_q   <= 1'b0;
               tlast_q    <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      M_AXIS_TDATA = '0;
      M_AXIS_TDATA[DATA_WIDTH-1 -: SAMPLE_WIDTH] = rd_data_q;
   end

   assign M_AXIS_TVALID = tvalid_q;
   assign M_AXIS_TLAST  = tlast_q;
   assign frame_overrun = overrun_q;
   assign overrun_count = count_q;

endmodule

// File: tb/tb_mono_frame_scheduler.sv
// Bench for mono_frame_scheduler: a frame-queue model predicts every output each cycle,
// and directed scenarios pin latency, overrun counts, saturation and mid-stream reset.
module tb_mono_frame_scheduler;

   localparam int FL = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [23:0] sample;
   logic        tready;
   logic        tvalid, tlast, ovr;
   logic [31:0] tdata;
   logic [15:0] cnt;
   logic        tvalid2, tlast2, ovr2;
   logic [31:0] tdata2;
   logic [3:0]  cnt2;
   logic        tready2 = 1'b0;

   always #5 clk = ~clk;

   mono_frame_scheduler dut (
      .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst),
      .mono_sample_valid(valid), .mono_sample(sample),
      .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready), .M_AXIS_TDATA(tdata),
      .M_AXIS_TLAST(tlast), .frame_overrun(ovr), .overrun_count(cnt)
   );

   mono_frame_scheduler #(.CNT_WIDTH(4)) dut_sat (
      .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst),
      .mono_sample_valid(valid), .mono_sample(sample),
      .M_AXIS_TVALID(tvalid2), .M_AXIS_TREADY(tready2), .M_AXIS_TDATA(tdata2),
      .M_AXIS_TLAST(tlast2), .frame_overrun(ovr2), .overrun_count(cnt2)
   );

   int pass_cnt = 0;
   int tot_cnt  = 0;
   bit armed    = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Model: samples of the frame being filled, samples of completed frames awaiting output
   logic [23:0] cur[$];
   logic [23:0] pend[$];
   bit          m_valid = 0;
   bit          m_lead  = 0;
   int          m_beat  = 0;
   bit          m_ovr   = 0;
   logic [15:0] m_cnt   = '0;

   always @(posedge clk) begin
      int  nf;
      bit  hs;
      bit  start;
      if (rst) begin
         cur.delete(); pend.delete();
         m_valid = 0; m_lead = 0; m_beat = 0; m_ovr = 0; m_cnt = '0;
      end else begin
         nf    = pend.size() / FL;
         hs    = m_valid && tready;
         start = !m_valid && !m_lead && (nf > 0);
         m_ovr = 0;
         if (valid) begin
            if (nf == 2) begin
               m_ovr = 1;
               if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end else begin
               cur.push_back(sample);
               if (cur.size() == FL) begin
                  foreach (cur[i]) pend.push_back(cur[i]);
                  cur.delete();
               end
            end
         end
         if (hs) begin
            if (m_beat == FL - 1) begin
               for (int i = 0; i < FL; i++) void'(pend.pop_front());
               m_valid = 0;
               m_beat  = 0;
            end else m_beat++;
         end else if (m_lead) begin
            m_lead  = 0;
            m_valid = 1;
         end else if (start) m_lead = 1;
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("tvalid", {31'd0, tvalid}, {31'd0, m_valid});
         chk("frame_overrun", {31'd0, ovr}, {31'd0, m_ovr});
         chk("overrun_count", {16'd0, cnt}, {16'd0, m_cnt});
         if (m_valid) begin
            chk("tdata", tdata, {pend[m_beat], 8'h00});
            chk("tlast", {31'd0, tlast}, {31'd0, (m_beat == FL - 1)});
         end
      end
   end

   int          beats = 0;
   int          lasts = 0;
   int          pulses = 0;
   logic [31:0] last_tdata = '0;

   always @(posedge clk) begin
      if (tvalid && tready) begin
         beats++;
         if (tlast) begin
            lasts++;
            last_tdata = tdata;
         end
      end
      if (ovr) pulses++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int n, input int base);
      for (int i = 0; i < n; i++) begin
         valid  = 1'b1;
         sample = 24'(base + i);
         tick();
      end
      valid = 1'b0;
   endtask

   task automatic drain(input bit rnd);
      bit done = 0;
      for (int k = 0; k < 4000; k++) begin
         if (rnd) tready = ($urandom_range(0, 1) != 0);
         else     tready = 1'b1;
         tick();
         if (!m_valid && !m_lead && pend.size() == 0) begin
            done = 1;
            break;
         end
      end
      tready = 1'b1;
      if (!done) begin
         tot_cnt++;
         $display("FAIL drain_timeout: frames still pending=%0d expected 0", pend.size() / FL);
      end
   endtask

   initial begin
      int b0, l0, p0;
      bit hit;
      rst = 1'b1; valid = 1'b0; sample = '0; tready = 1'b0;
      tick(); tick();
      armed = 1'b1;
      @(negedge clk);
      chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
      chk("rst_count", {16'd0, cnt}, 32'd0);
      tick();
      rst = 1'b0;

      // Ramp with latency check
      tready = 1'b1;
      b0 = beats; l0 = lasts;
      send(FL, 0);
      @(negedge clk);
      @(negedge clk);
      chk("lat_fetch_tvalid", {31'd0, tvalid}, 32'd0);
      @(negedge clk);
      chk("lat_first_tvalid", {31'd0, tvalid}, 32'd1);
      chk("lat_first_tdata", tdata, 32'h0000_0000);
      drain(0);
      chk("ramp_beats", beats - b0, 32'd256);
      chk("ramp_lasts", lasts - l0, 32'd1);
      chk("ramp_last_tdata", last_tdata, 32'h0000_FF00);

      // Ping-pong back-to-back
      b0 = beats; l0 = lasts; p0 = pulses;
      send(2 * FL, 0);
      drain(0);
      chk("pp_beats", beats - b0, 32'd512);
      chk("pp_lasts", lasts - l0, 32'd2);
      chk("pp_no_overrun", pulses - p0, 32'd0);
      chk("pp_last_tdata", last_tdata, 32'h0001_FF00);

      // Random backpressure
      b0 = beats;
      send(FL, 0);
      drain(1);
      chk("bp_beats", beats - b0, 32'd256);
      chk("bp_last_tdata", last_tdata, 32'h0000_FF00);

      // Overrun with both banks held
      tready = 1'b0;
      b0 = beats; p0 = pulses;
      send(600, 0);
      @(negedge clk);
      chk("ovr_count", {16'd0, cnt}, 32'd88);
      tick(); tick();
      chk("ovr_pulses", pulses - p0, 32'd88);
      drain(0);
      chk("ovr_beats", beats - b0, 32'd512);
      chk("ovr_last_tdata", last_tdata, 32'h0001_FF00);

      // Saturation on the 4-bit counter instance
      rst = 1'b1; tick(); rst = 1'b0;
      tready = 1'b0;
      send(530, 0);
      @(negedge clk);
      chk("sat_count4", {28'd0, cnt2}, 32'd15);
      chk("sat_count16", {16'd0, cnt}, 32'd18);
      drain(0);

      // Reset in the middle of a frame
      tready = 1'b0;
      send(520, 1000);
      tready = 1'b1;
      b0  = beats;
      hit = 0;
      for (int k = 0; k < 2000; k++) begin
         if (beats - b0 >= 100) begin
            hit = 1;
            break;
         end
         tick();
      end
      if (!hit) begin
         tot_cnt++;
         $display("FAIL midrst_wait: beats=%0d expected 100", beats - b0);
      end
      rst = 1'b1; tick(); rst = 1'b0;
      @(negedge clk);
      chk("midrst_tvalid", {31'd0, tvalid}, 32'd0);
      chk("midrst_count", {16'd0, cnt}, 32'd0);
      tick();
      b0 = beats; l0 = lasts;
      send(FL, -500);
      drain(0);
      chk("midrst_beats", beats - b0, 32'd256);
      chk("midrst_lasts", lasts - l0, 32'd1);
      chk("midrst_last_tdata", last_tdata, 32'hFFFF_0B00);

      armed = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
